// File: rtl/patternbuf_player.sv
`default_nettype none
// ============================================================================
//  Module      : patternbuf_player
//  Description : DEPTH x WIDTH pattern buffer. It is loaded by a serial scan
//                chain or by a binary-addressed parallel write. It has a
//                registered random-read port and a playback sequencer that
//                streams a window of entries over a valid/ready handshake.
//                Optional feature macro: PATBUF_LOOP_CNT_EN adds the
//                play_loops pass counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module patternbuf_player #(
    parameter int WIDTH = 8,             // bits per entry (>= 2)
    parameter int DEPTH = 32,            // entries, power of two, >= 2
    parameter int AW    = $clog2(DEPTH)  // derived; do not override
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ssel,
    input  logic             sin,
    output logic             sout,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             play_start,
    input  logic [AW-1:0]    play_base,
    input  logic [AW-1:0]    play_len,
    input  logic             play_loop,
    input  logic             play_stop,
    output logic [WIDTH-1:0] play_data,
    output logic             play_valid,
    input  logic             play_ready,
`ifdef PATBUF_LOOP_CNT_EN
    output logic [15:0]      play_loops,
`endif
    output logic             play_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_play_data;
    logic             r_play_valid;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    r_base;
    logic [AW-1:0]    r_len;
    logic             r_loop;
    logic             w_busy;

    // Handshake and sequencing qualifiers shared by the FSM and the datapath.
    logic          w_accept;
    logic          w_last;
    logic          w_start;
    logic          w_run_ok;
    logic [AW-1:0] w_ptr_inc;

    assign w_accept  = r_play_valid & play_ready;
    assign w_last    = (r_cnt == r_len);
    assign w_start   = (r_state == S_IDLE) & play_start & ~ssel;
    // In RUN the sequencer only advances when neither a shift nor a stop preempts it.
    assign w_run_ok  = (r_state == S_RUN) & ~ssel & ~play_stop & w_accept;
    // DEPTH is a power of two, so the AW-bit add wraps DEPTH-1 -> 0 by itself.
    assign w_ptr_inc = r_ptr + 1'b1;

    assign sout       = r_mem[DEPTH-1][WIDTH-1];
    assign rd_data    = r_rd_data;
    assign play_data  = r_play_data;
    assign play_valid = r_play_valid;
    assign play_busy  = w_busy;

    // Storage: scan shift wins over the parallel write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (ssel) begin
            r_mem[0] <= {r_mem[0][WIDTH-2:0], sin};
            for (int i = 1; i < DEPTH; i++)
                r_mem[i] <= {r_mem[i][WIDTH-2:0], r_mem[i-1][WIDTH-1]};
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Random-read port: reads the pre-edge array, so a colliding write returns old data.
    always_ff @(posedge clk) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= r_mem[rd_addr];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic: shift and stop both abort a running window.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (ssel || play_stop || (w_accept && w_last && !r_loop))
                         w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_busy = (r_state == S_RUN);
    end

    // Playback datapath: window latch, pointer/beat counter and the output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_play_data  <= '0;
            r_play_valid <= 1'b0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_base       <= '0;
            r_len        <= '0;
            r_loop       <= 1'b0;
        end else if (ssel) begin
            r_play_valid <= 1'b0;
        end else if (w_start) begin
            r_base       <= play_base;
            r_len        <= play_len;
            r_loop       <= play_loop;
            r_ptr        <= play_base;
            r_cnt        <= '0;
            r_play_data  <= r_mem[play_base];
            r_play_valid <= 1'b1;
        end else if (r_state == S_RUN) begin
            if (play_stop) begin
                r_play_valid <= 1'b0;
            end else if (w_accept) begin
                if (!w_last) begin
                    r_ptr       <= w_ptr_inc;
                    r_cnt       <= r_cnt + 1'b1;
                    r_play_data <= r_mem[w_ptr_inc];
                end else if (r_loop) begin
                    r_ptr       <= r_base;
                    r_cnt       <= '0;
                    r_play_data <= r_mem[r_base];
                end else begin
                    r_play_valid <= 1'b0;
                end
            end
        end
    end

`ifdef PATBUF_LOOP_CNT_EN
    logic [15:0] r_loops;
    assign play_loops = r_loops;

    // Completed-pass counter: steps on each wrap back to base, saturating.
    always_ff @(posedge clk) begin
        if (reset || w_start)
            r_loops <= '0;
        else if (w_run_ok && w_last && r_loop && (r_loops != 16'hFFFF))
            r_loops <= r_loops + 16'd1;
    end
`endif

endmodule
`default_nettype wire
